dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, meaning number of 32-bit words stored (power of two, 16..65536).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning added access wait states (0..15).
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  the MEM stage presents a request.
REQ-006 SHALL have port req_ready  output  1  the responder accepts a request this cycle.
REQ-007 SHALL have port req_write  input  1  1 = store word, 0 = load word.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port rsp_valid  output  1  response available.
REQ-011 SHALL have port rsp_ready  input  1  the requester takes the response.
REQ-012 SHALL have port rsp_rdata  output  32  load data (0 for stores and errors).
REQ-013 SHALL have port rsp_err  output  1  request was misaligned or out of range.
REQ-014 SHALL have ports rd_count, wr_count and err_count  output  16 each  statistics counters.

Function
REQ-015 SHALL implement the FSM states IDLE, WAIT and RESP.
REQ-016 SHALL drive req_ready = 1 in IDLE, 0 in WAIT, and rsp_ready in RESP.
REQ-017 SHALL accept a request at an edge where req_valid & req_ready are both 1, and latch write, address and data.
REQ-018 SHALL, on accept, load the wait counter with WAIT_CYCLES; if WAIT_CYCLES = 0 it goes straight to RESP, otherwise to WAIT.
REQ-019 SHALL, in WAIT, decrement the counter every edge and move to RESP at the edge where the counter equals 1.
REQ-020 SHALL raise rsp_valid at accept edge + WAIT_CYCLES, i.e. visible in cycle WAIT_CYCLES+1 counting the accept cycle as cycle 0.
REQ-021 SHALL perform the memory access (write commit or read sample) on the edge that enters RESP, never earlier.
REQ-022 SHALL form the word index as req_addr[log2(DEPTH)+1:2].
REQ-023 SHALL flag an error when req_addr[1:0] != 0 or req_addr >= 4*DEPTH; an error request performs no access and returns rsp_err = 1, rsp_rdata = 0.
REQ-024 SHALL keep rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready = 1.
REQ-025 SHALL, on an edge with RESP & rsp_ready, go to IDLE if req_valid = 0, or accept the new request (back-to-back, REQ-018) if req_valid = 1.
REQ-026 SHALL make a load issued immediately after a store to the same address return the stored data.
REQ-027 SHALL increment rd_count, wr_count and err_count on each response handshake of the matching kind (an error counts only in err_count), saturating at 16'hFFFF.
REQ-028 SHALL ignore req_* inputs outside an accept edge.

Reset
REQ-029 SHALL, on reset, force state = IDLE, wait counter = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0 and all counters = 0.
REQ-030 SHALL leave memory contents unaffected by reset.
REQ-031 SHALL drop a request pending in WAIT when reset is asserted; a store not yet committed is lost, and no response is produced.
REQ-032 SHALL hold req_ready = 1 in the first cycle after reset release.

Structure
REQ-033 SHALL place the FSM state encoding, default DEPTH/WAIT_CYCLES and the counter width in the shared package dmem_pkg.
REQ-034 SHALL instantiate one sub-module, dmem_array: a single-port synchronous word RAM with write enable and registered read data.

Verification
REQ-035 SHALL cover: with WAIT_CYCLES=2, store 0xDEADBEEF to 0x10, then load 0x10 -> rsp_valid in cycle 3 of each request, load rsp_rdata = 0xDEADBEEF, rsp_err = 0.
REQ-036 SHALL cover: load 0x12 and load 4*DEPTH -> both responses give rsp_err = 1, rsp_rdata = 0, err_count = 2, memory unchanged.
REQ-037 SHALL cover: hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid and rsp_rdata stable throughout and req_ready = 0.
REQ-038 SHALL cover: rsp_ready = 1 and req_valid = 1 continuously for 4 loads -> one response every WAIT_CYCLES+1 cycles with no idle gap, rd_count = 4.
REQ-039 SHALL cover: assert reset during WAIT of a store of 0x12345678 to 0x20 -> no response, counters = 0, a later load of 0x20 returns the old value.
REQ-040 SHALL cover: with WAIT_CYCLES=0, preload rd_count = 16'hFFFE, then do 3 loads -> rsp_valid 1 cycle after each accept, rd_count saturates at 16'hFFFF.

Source files
------------

// File: rtl/dmem_pkg.sv
// dmem_pkg: shared state encoding, defaults and counter helpers for the data-memory responder
package dmem_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  localparam int DEF_DEPTH = 1024;
  localparam int DEF_WAIT = 2;
  localparam int CNT_W = 16;
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return &c ? c : c + CNT_W'(1);
  endfunction
endpackage

// File: rtl/dmem_array.sv
// dmem_array: single-port synchronous word RAM with write enable and registered read data
module dmem_array import dmem_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);
  logic [31:0] mem [DEPTH];
  // one access per enabled edge; the read returns the pre-write contents
  always_ff @(posedge clk)
    if (en) begin
      if (we) mem[addr] <= wdata;
      rdata <= mem[addr];
    end
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: valid/ready data-memory slave with fixed wait states, error checks and statistics
module dmem_responder import dmem_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH,
  parameter int WAIT_CYCLES = DEF_WAIT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_write,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic             rsp_err,
  output logic [CNT_W-1:0] rd_count,
  output logic [CNT_W-1:0] wr_count,
  output logic [CNT_W-1:0] err_count
);
  localparam int AW = $clog2(DEPTH);
  state_t state, state_n;
  logic [3:0] cnt;
  logic lat_w, err_q, accept, hs, go_resp, a_w, a_err;
  logic [31:0] lat_addr, lat_wdata, a_addr, a_wdata, ram_q;
  assign req_ready = state == IDLE || (state == RESP && rsp_ready);
  assign accept = req_valid && req_ready;
  assign hs = state == RESP && rsp_ready;
  // with no wait states the access happens on the accept edge itself, before the latch holds the request
  assign a_w = WAIT_CYCLES == 0 ? req_write : lat_w;
  assign a_addr = WAIT_CYCLES == 0 ? req_addr : lat_addr;
  assign a_wdata = WAIT_CYCLES == 0 ? req_wdata : lat_wdata;
  assign a_err = |a_addr[1:0] || a_addr >= 32'(4 * DEPTH);
  assign rsp_valid = state == RESP;
  assign rsp_err = rsp_valid && err_q;
  assign rsp_rdata = rsp_valid && !err_q && !lat_w ? ram_q : '0;
  // next state and the strobe marking the edge that enters RESP
  always_comb begin
    state_n = state;
    go_resp = 1'b0;
    if (accept) begin
      state_n = WAIT_CYCLES == 0 ? RESP : WAIT;
      go_resp = WAIT_CYCLES == 0;
    end else if (state == WAIT && cnt == 4'd1) begin
      state_n = RESP;
      go_resp = 1'b1;
    end else if (hs) state_n = IDLE;
  end
  // state register, wait counter, request latch and error flag
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      lat_w <= 1'b0;
      lat_addr <= '0;
      lat_wdata <= '0;
      err_q <= 1'b0;
    end else begin
      state <= state_n;
      if (accept) begin
        cnt <= 4'(WAIT_CYCLES);
        lat_w <= req_write;
        lat_addr <= req_addr;
        lat_wdata <= req_wdata;
      end else if (state == WAIT) cnt <= cnt - 4'd1;
      if (go_resp) err_q <= a_err;
    end
  // statistics bump on each response handshake, classified by the request being retired
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      rd_count <= '0;
      wr_count <= '0;
      err_count <= '0;
    end else if (hs) begin
      if (err_q) err_count <= sat_inc(err_count);
      else if (lat_w) wr_count <= sat_inc(wr_count);
      else rd_count <= sat_inc(rd_count);
    end
  dmem_array #(.DEPTH(DEPTH)) u_array (
    .clk(clk),
    .en(go_resp && !a_err),
    .we(a_w),
    .addr(a_addr[AW+1:2]),
    .wdata(a_wdata),
    .rdata(ram_q)
  );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and randomized checks of two responder instances against a word-map model
module tb_dmem_responder;
  localparam int DA = 1024, WA = 2, DB = 16;
  logic clk = 1'b0, ra, rb;
  logic a_req_valid, a_req_ready, a_req_write, a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [31:0] a_req_addr, a_req_wdata, a_rsp_rdata;
  logic [15:0] a_rd, a_wr, a_er;
  logic b_req_valid, b_req_ready, b_req_write, b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_rsp_rdata;
  logic [15:0] b_rd, b_wr, b_er;
  int n_cmp = 0, n_bad = 0;
  int rd_m = 0, wr_m = 0, er_m = 0, rdb_m = 0;
  logic [31:0] mdl [int];
  always #5 clk = ~clk;
  dmem_responder #(.DEPTH(DA), .WAIT_CYCLES(WA)) dut_a (
    .clk(clk), .reset(ra), .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_write(a_req_write), .req_addr(a_req_addr), .req_wdata(a_req_wdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
    .rsp_err(a_rsp_err), .rd_count(a_rd), .wr_count(a_wr), .err_count(a_er));
  dmem_responder #(.DEPTH(DB), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .reset(rb), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_write(b_req_write), .req_addr(b_req_addr), .req_wdata(b_req_wdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
    .rsp_err(b_rsp_err), .rd_count(b_rd), .wr_count(b_wr), .err_count(b_er));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic int sat(input int c);
    return c >= 65535 ? 65535 : c + 1;
  endfunction
  task automatic chk_cnt_a();
    chk("a_rd_count", 32'(a_rd), rd_m);
    chk("a_wr_count", 32'(a_wr), wr_m);
    chk("a_err_count", 32'(a_er), er_m);
  endtask
  task automatic txn(input logic w, input logic [31:0] a, input logic [31:0] d, input int hold);
    logic e;
    logic [31:0] ex;
    e = a[1:0] != 2'b00 || a >= 32'(4 * DA);
    ex = (e || w) ? 32'd0 : mdl[int'(a >> 2)];
    @(negedge clk);
    a_req_valid = 1'b1;
    a_req_write = w;
    a_req_addr = a;
    a_req_wdata = d;
    chk("req_ready_idle", 32'(a_req_ready), 1);
    @(posedge clk);
    #1;
    a_req_valid = 1'($urandom);
    a_req_write = 1'($urandom);
    a_req_addr = $urandom;
    a_req_wdata = $urandom;
    for (int n = 1; n <= WA; n++) begin
      @(negedge clk);
      chk("valid_in_wait", 32'(a_rsp_valid), 0);
    end
    @(negedge clk);
    chk("rsp_valid", 32'(a_rsp_valid), 1);
    chk("rsp_rdata", a_rsp_rdata, ex);
    chk("rsp_err", 32'(a_rsp_err), 32'(e));
    if (!e && w) mdl[int'(a >> 2)] = d;
    for (int h = 0; h < hold; h++) begin
      a_req_valid = 1'($urandom);
      a_req_addr = $urandom;
      @(negedge clk);
      chk("hold_valid", 32'(a_rsp_valid), 1);
      chk("hold_rdata", a_rsp_rdata, ex);
      chk("hold_req_ready", 32'(a_req_ready), 0);
    end
    a_req_valid = 1'b0;
    a_rsp_ready = 1'b1;
    #1;
    chk("req_ready_resp", 32'(a_req_ready), 1);
    @(posedge clk);
    #1;
    a_rsp_ready = 1'b0;
    if (e) er_m = sat(er_m);
    else if (w) wr_m = sat(wr_m);
    else rd_m = sat(rd_m);
    @(negedge clk);
    chk("idle_after_rsp", 32'(a_rsp_valid), 0);
    chk_cnt_a();
  endtask
  initial begin
    int k, cyc, last, n;
    logic [31:0] addr;
    ra = 1'b1; rb = 1'b1;
    {a_req_valid, a_req_write, a_rsp_ready} = '0;
    {b_req_valid, b_req_write, b_rsp_ready} = '0;
    a_req_addr = '0; a_req_wdata = '0; b_req_addr = '0; b_req_wdata = '0;
    #1;
    chk("reset_rsp_valid", 32'(a_rsp_valid), 0);
    chk("reset_rsp_rdata", a_rsp_rdata, 0);
    chk("reset_rsp_err", 32'(a_rsp_err), 0);
    chk_cnt_a();
    repeat (3) @(negedge clk);
    ra = 1'b0; rb = 1'b0;
    @(negedge clk);
    chk("ready_after_release", 32'(a_req_ready), 1);
    txn(1'b1, 32'h10, 32'hDEADBEEF, 0);
    txn(1'b0, 32'h10, 32'h0, 0);
    txn(1'b0, 32'h12, 32'h0, 1);
    txn(1'b0, 32'(4 * DA), 32'h0, 0);
    txn(1'b1, 32'h11, 32'h11111111, 0);
    txn(1'b1, 32'(4 * DA) + 32'h10, 32'h22222222, 0);
    txn(1'b0, 32'h10, 32'h0, 5);
    for (int i = 0; i < 4; i++) txn(1'b1, 32'h40 + 32'(4 * i), 32'hA0000000 + 32'(i), 0);
    @(negedge clk);
    a_rsp_ready = 1'b1; a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 32'h40;
    k = 0; cyc = 0; last = 0;
    while (k < 4 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (a_rsp_valid) begin
        chk("b2b_rdata", a_rsp_rdata, mdl[16 + k]);
        chk("b2b_spacing", cyc - last, WA + 1);
        last = cyc;
        k++;
        if (k < 4) a_req_addr = 32'h40 + 32'(4 * k);
        else a_req_valid = 1'b0;
      end
    end
    chk("b2b_responses", k, 4);
    @(posedge clk);
    #1;
    a_rsp_ready = 1'b0;
    for (int i = 0; i < k; i++) rd_m = sat(rd_m);
    @(negedge clk);
    chk_cnt_a();
    txn(1'b1, 32'h20, 32'hA5A50000, 0);
    @(negedge clk);
    a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 32'h20; a_req_wdata = 32'h12345678;
    @(posedge clk);
    #1;
    a_req_valid = 1'b0;
    @(negedge clk);
    ra = 1'b1;
    rd_m = 0; wr_m = 0; er_m = 0;
    #1;
    chk("rst_wait_valid", 32'(a_rsp_valid), 0);
    chk_cnt_a();
    repeat (2) @(negedge clk);
    ra = 1'b0;
    @(negedge clk);
    chk("rst_release_ready", 32'(a_req_ready), 1);
    repeat (3) begin
      @(negedge clk);
      chk("rst_no_rsp", 32'(a_rsp_valid), 0);
    end
    chk_cnt_a();
    txn(1'b0, 32'h20, 32'h0, 0);
    for (int i = 0; i < 40; i++) begin
      k = $urandom_range(0, 7);
      addr = 32'h100 + 32'(4 * k);
      n = $urandom_range(0, 7);
      if (n == 0) addr = addr | 32'($urandom_range(1, 3));
      else if (n == 1) addr = 32'(4 * DA) + 32'(4 * $urandom_range(0, 255));
      txn((n > 1 && !mdl.exists(int'(addr >> 2))) ? 1'b1 : 1'($urandom), addr, $urandom,
          $urandom_range(0, 3));
    end
    b_rsp_ready = 1'b1;
    @(negedge clk);
    b_req_valid = 1'b1; b_req_write = 1'b1; b_req_addr = 32'h8; b_req_wdata = 32'h0BADF00D;
    @(posedge clk);
    #1;
    b_req_valid = 1'b0; b_req_write = 1'b0;
    @(negedge clk);
    chk("b_store_valid", 32'(b_rsp_valid), 1);
    chk("b_store_rdata", b_rsp_rdata, 0);
    @(negedge clk);
    chk("b_wr_count", 32'(b_wr), 1);
    b_req_valid = 1'b1;
    n = 0; cyc = 0;
    while (n < 65534 && cyc < 70000) begin
      @(negedge clk);
      cyc++;
      if (b_rsp_valid) n++;
      if (b_rsp_valid && n == 1) chk("b_stream_rdata", b_rsp_rdata, 32'h0BADF00D);
      if (n == 65534) b_req_valid = 1'b0;
    end
    chk("b_stream_count", n, 65534);
    b_req_valid = 1'b0;
    for (int i = 0; i < n; i++) rdb_m = sat(rdb_m);
    @(negedge clk);
    chk("b_rd_preload", 32'(b_rd), rdb_m);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      b_req_valid = 1'b1;
      chk("b_accept_cycle_idle", 32'(b_rsp_valid), 0);
      @(posedge clk);
      #1;
      b_req_valid = 1'b0;
      @(negedge clk);
      chk("b_one_cycle_valid", 32'(b_rsp_valid), 1);
      chk("b_load_rdata", b_rsp_rdata, 32'h0BADF00D);
      rdb_m = sat(rdb_m);
      @(negedge clk);
      chk("b_rd_sat", 32'(b_rd), rdb_m);
      chk("b_idle_after", 32'(b_rsp_valid), 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
